// File: rtl/instr_fetch_unit_if.sv
// Bundle for the fetch unit: the core-side instruction handshake and
// redirect/halt controls, plus the instruction-memory req/ack bus.
interface instr_fetch_unit_if;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        instr_ready;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        misaligned_err;

   // Fetch unit view: drives memory requests and the instruction stream.
   modport master (
      input  redirect, redirect_pc, halt, instr_ready, mem_ack, mem_rdata,
      output instr_valid, instr, instr_pc, mem_req, mem_addr, misaligned_err
   );

   // Core plus memory view.
   modport slave (
      output redirect, redirect_pc, halt, instr_ready, mem_ack, mem_rdata,
      input  instr_valid, instr, instr_pc, mem_req, mem_addr, misaligned_err
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: prefetches words over a req/ack memory bus into a
// small PC-tagged FIFO and hands them to the core through valid/ready.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   instr_fetch_unit_if.master  bus
);

   localparam int PtrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} FetchState;

   FetchState         state, stateNext;
   logic [PtrW-1:0]   rdPtr, wrPtr;
   logic [CntW-1:0]   count, countNext;
   logic [31:0]       pcMem   [FIFO_DEPTH];
   logic [31:0]       wordMem [FIFO_DEPTH];
   logic [31:0]       fetchPc, fetchPcNext, reqAddr;
   logic              errFlag;
   logic              push, pop, issue, room, headValid;

   assign headValid = (count != '0);
   assign push      = (state == REQ) && bus.mem_ack && !bus.redirect;
   assign pop       = headValid && bus.instr_ready && !bus.redirect;

   // Occupancy after this cycle's push/pop; a redirect flushes everything.
   always_comb begin
      countNext = count + CntW'(push) - CntW'(pop);
      if (bus.redirect) begin
         countNext = '0;
      end
   end

   assign room = (countNext < DepthC);

   always_comb begin
      fetchPcNext = fetchPc;
      if (bus.redirect) begin
         fetchPcNext = {bus.redirect_pc[31:2], 2'b00};
      end else if (push) begin
         fetchPcNext = fetchPc + 32'd4;
      end
   end

   // Issue is only allowed when the word it will return is guaranteed a slot.
   always_comb begin
      stateNext = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.halt && !bus.redirect && room) begin
               stateNext = REQ;
               issue     = 1'b1;
            end
         end
         REQ: begin
            if (bus.mem_ack) begin
               if (!bus.redirect && !bus.halt && room) begin
                  issue = 1'b1;
               end else begin
                  stateNext = IDLE;
               end
            end else if (bus.redirect) begin
               stateNext = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.mem_ack) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         fetchPc <= RESET_PC;
         reqAddr <= RESET_PC;
         count   <= '0;
         rdPtr   <= '0;
         wrPtr   <= '0;
         errFlag <= 1'b0;
      end else begin
         state   <= stateNext;
         fetchPc <= fetchPcNext;
         count   <= countNext;
         if (issue) begin
            reqAddr <= fetchPcNext;
         end
         if (bus.redirect) begin
            rdPtr <= '0;
            wrPtr <= '0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
               errFlag <= 1'b1;
            end
         end else begin
            if (push) begin
               wrPtr <= wrPtr + PtrW'(1);
            end
            if (pop) begin
               rdPtr <= rdPtr + PtrW'(1);
            end
         end
      end
   end

   // Storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         pcMem[wrPtr]   <= reqAddr;
         wordMem[wrPtr] <= bus.mem_rdata;
      end
   end

   assign bus.mem_req        = (state != IDLE);
   assign bus.mem_addr       = reqAddr;
   assign bus.instr_valid    = headValid;
   assign bus.instr          = headValid ? wordMem[rdPtr] : 32'h0;
   assign bus.instr_pc       = headValid ? pcMem[rdPtr]   : 32'h0;
   assign bus.misaligned_err = errFlag;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, all
// compared against a transaction-level model of the fetch queue.
module tb_instr_fetch_unit;

   localparam int          Depth   = 4;
   localparam logic [31:0] ResetPc = 32'h0000_0000;
   localparam logic [31:0] DataKey = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic reset;
   int   testCount = 0;
   int   failCount = 0;

   instr_fetch_unit_if bus();

   instr_fetch_unit #(.RESET_PC(ResetPc), .FIFO_DEPTH(Depth)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: queued {pc, word} pairs plus the single outstanding fetch.
   logic [31:0] qPc[$];
   logic [31:0] qWord[$];
   logic [31:0] mFetchPc, mReqAddr;
   logic        mBusy, mDiscard, mErr;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      qPc.delete();
      qWord.delete();
      mFetchPc = ResetPc;
      mReqAddr = ResetPc;
      mBusy    = 1'b0;
      mDiscard = 1'b0;
      mErr     = 1'b0;
   endtask

   task automatic checkModel();
      checkOutput("mem_req", 32'(bus.mem_req), 32'(mBusy));
      if (mBusy) checkOutput("mem_addr", bus.mem_addr, mReqAddr);
      checkOutput("instr_valid", 32'(bus.instr_valid), 32'(qPc.size() != 0));
      checkOutput("instr_pc", bus.instr_pc, (qPc.size() != 0) ? qPc[0] : 32'h0);
      checkOutput("instr", bus.instr, (qWord.size() != 0) ? qWord[0] : 32'h0);
      checkOutput("misaligned_err", 32'(bus.misaligned_err), 32'(mErr));
   endtask

   task automatic updateModel(input logic ack, input logic [31:0] rdata, input logic rdir,
                              input logic [31:0] rpc, input logic hlt, input logic rdy);
      logic pop, accepted, drainDone;
      pop       = (qPc.size() != 0) && rdy;
      accepted  = mBusy && ack;
      drainDone = accepted && mDiscard;
      if (rdir) begin
         qPc.delete();
         qWord.delete();
         mFetchPc = {rpc[31:2], 2'b00};
         if (rpc[1:0] != 2'b00) mErr = 1'b1;
         if (accepted) begin
            mBusy    = 1'b0;
            mDiscard = 1'b0;
         end else if (mBusy) begin
            mDiscard = 1'b1;
         end
      end else begin
         if (accepted) begin
            if (!mDiscard) begin
               qPc.push_back(mReqAddr);
               qWord.push_back(rdata);
               mFetchPc = mFetchPc + 32'd4;
            end
            mBusy    = 1'b0;
            mDiscard = 1'b0;
         end
         if (pop) begin
            void'(qPc.pop_front());
            void'(qWord.pop_front());
         end
         if (!mBusy && !hlt && !drainDone && qPc.size() < Depth) begin
            mBusy    = 1'b1;
            mReqAddr = mFetchPc;
         end
      end
   endtask

   // One clock: check, drive, clock edge, advance model; returns at the negedge.
   task automatic applyStimulus(input logic ack, input logic rdir, input logic [31:0] rpc,
                                input logic hlt, input logic rdy);
      logic [31:0] rdata;
      checkModel();
      rdata           = mBusy ? (mReqAddr ^ DataKey) : $urandom;
      bus.mem_ack     = ack;
      bus.mem_rdata   = rdata;
      bus.redirect    = rdir;
      bus.redirect_pc = rpc;
      bus.halt        = hlt;
      bus.instr_ready = rdy;
      @(posedge clk);
      updateModel(ack, rdata, rdir, rpc, hlt, rdy);
      @(negedge clk);
   endtask

   task automatic doReset();
      #2 reset = 1'b1;
      #1 checkOutput("asyncReqDrop", 32'(bus.mem_req), 32'h0);
      bus.mem_ack     = 1'b0;
      bus.mem_rdata   = 32'h0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.halt        = 1'b0;
      bus.instr_ready = 1'b0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_mem_req", 32'(bus.mem_req), 32'h0);
      checkOutput("rst_mem_addr", bus.mem_addr, ResetPc);
      checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
      checkOutput("rst_instr", bus.instr, 32'h0);
      checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
      checkOutput("rst_misaligned", 32'(bus.misaligned_err), 32'h0);
      reset = 1'b0;
   endtask

   initial begin
      int          firstValid;
      int          ackCount;
      int          haltLeft;
      logic [31:0] rpc;
      logic        rdir, hlt;

      reset = 1'b1;
      @(negedge clk);
      doReset();

      // Sequential fetch with zero-wait memory and a always-ready core.
      firstValid = -1;
      for (int i = 0; i < 12; i++) begin
         if (bus.instr_valid && firstValid < 0) firstValid = i;
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      end
      checkOutput("firstValidCycle", 32'(firstValid), 32'd2);

      // Stalled core: only FIFO_DEPTH acks may be accepted, then drain in order.
      doReset();
      ackCount = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.mem_req) ackCount++;
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      end
      checkOutput("stallAckCount", 32'(ackCount), 32'(Depth));
      checkOutput("stallNoReq", 32'(bus.mem_req), 32'h0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

      // Redirect while the fetch of 0x8 waits on a delayed ack.
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("pendingAddr8", bus.mem_addr, 32'h8);
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
      checkOutput("flushEmpty", 32'(bus.instr_valid), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("drainDiscard", 32'(bus.instr_valid), 32'h0);
      checkOutput("redirReq", 32'(bus.mem_req), 32'h1);
      checkOutput("redirAddr", bus.mem_addr, 32'h100);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

      // Misaligned redirect target.
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h202, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("misalignAddr", bus.mem_addr, 32'h200);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("misalignSticky", 32'(bus.misaligned_err), 32'h1);

      // Halt with an outstanding request.
      doReset();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("haltNoReq", 32'(bus.mem_req), 32'h0);
      checkOutput("haltKeptPc", bus.instr_pc, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("haltResumeAddr", bus.mem_addr, 32'h4);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

      // Redirect, pop and ack together; then reset in the middle of a fetch.
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h340, 1'b0, 1'b1);
      checkOutput("tripleEmpty", 32'(bus.instr_valid), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("tripleAddr", bus.mem_addr, 32'h340);
      doReset();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("strayAckIgnored", 32'(bus.instr_valid), 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

      // Random traffic: variable memory latency, back-pressure, redirects, halts.
      doReset();
      haltLeft = 0;
      for (int i = 0; i < 600; i++) begin
         rdir = ($urandom_range(0, 19) == 0);
         rpc  = $urandom_range(0, 32'h0000_FFFF);
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         if (haltLeft == 0 && $urandom_range(0, 24) == 0) haltLeft = $urandom_range(1, 8);
         hlt = (haltLeft != 0);
         if (haltLeft != 0) haltLeft--;
         applyStimulus(1'($urandom_range(0, 1)), rdir, rpc, hlt,
                       ($urandom_range(0, 9) < 6));
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
